// File: rtl/nco_tick_scheduler.sv
// nco_tick_scheduler: round-robin shared-adder NCO bank with tick/level outputs.
// Optional NCO_PHASE_CLR_EN: config apply with en=1 restarts phase at the new step.
module nco_tick_scheduler #(
  parameter  int NCH = 4,
  parameter  int W   = 32,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_step,
  input  logic           cfg_en,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] level,
  output logic [CW-1:0]  slot
);

  localparam logic [CW-1:0] LAST  = CW'(NCH - 1);
  localparam logic [CW:0]   NCH_L = (CW + 1)'(NCH);

  logic [CW-1:0]  slot_q, slot_d;
  logic [W-1:0]   phase_q [NCH];
  logic [W-1:0]   phase_d [NCH];
  logic [W-1:0]   step_q  [NCH];
  logic [W-1:0]   step_d  [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] level_q, level_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  pch_q, pch_d;
  logic [W-1:0]   pstep_q, pstep_d;
  logic           pen_q, pen_d;

  logic           accept;
  logic           bad;
  logic           apply;
  logic           eff_en;
  logic [W-1:0]   eff_step;
  logic [W-1:0]   base;
  logic [W:0]     sum;

  assign cfg_ready = !pend_q && !rst;
  assign tick      = tick_q;
  assign level     = level_q;
  assign slot      = slot_q;

  // Service the current slot through the shared adder and run the config buffer.
  always_comb begin
    slot_d   = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    phase_d  = phase_q;
    step_d   = step_q;
    en_d     = en_q;
    tick_d   = '0;
    level_d  = level_q;
    pend_d   = pend_q;
    pch_d    = pch_q;
    pstep_d  = pstep_q;
    pen_d    = pen_q;
    accept   = cfg_valid && cfg_ready;
    bad      = pend_q && ({1'b0, pch_q} >= NCH_L);
    apply    = pend_q && !bad && (pch_q == slot_q);
    eff_en   = apply ? pen_q   : en_q[slot_q];
    eff_step = apply ? pstep_q : step_q[slot_q];
`ifdef NCO_PHASE_CLR_EN
    base     = apply ? '0 : phase_q[slot_q];
`else
    base     = phase_q[slot_q];
`endif
    sum      = {1'b0, base} + {1'b0, eff_step};
    if (apply) begin
      step_d[slot_q] = pstep_q;
      en_d[slot_q]   = pen_q;
    end
    if (eff_en) begin
      phase_d[slot_q] = sum[W-1:0];
      tick_d[slot_q]  = sum[W];
      level_d[slot_q] = sum[W-1];
    end else if (apply) begin
      phase_d[slot_q] = '0;
      level_d[slot_q] = 1'b0;
    end
    if (bad || apply) begin
      pend_d = 1'b0;
    end
    if (accept) begin
      pend_d  = 1'b1;
      pch_d   = cfg_ch;
      pstep_d = cfg_step;
      pen_d   = cfg_en;
    end
  end

  // State registers with synchronous reset; reset drops any pending config.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        phase_q[i] <= '0;
        step_q[i]  <= '0;
      end
      en_q    <= '0;
      tick_q  <= '0;
      level_q <= '0;
      pend_q  <= 1'b0;
      pch_q   <= '0;
      pstep_q <= '0;
      pen_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      pch_q   <= pch_d;
      pstep_q <= pstep_d;
      pen_q   <= pen_d;
    end
  end

endmodule

// File: tb/tb_nco_tick_scheduler.sv
// tb_nco_tick_scheduler: arithmetic NCO model plus directed literal checks.
// A small NCH=3/W=8 instance covers the out-of-range channel case.
module tb_nco_tick_scheduler;
  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_en = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [W-1:0]   cfg_step = '0;
  logic           cfg_ready;
  logic [NCH-1:0] tick, level;
  logic [CW-1:0]  slot;

  logic           c3_valid = 1'b0;
  logic           c3_en = 1'b0;
  logic [1:0]     c3_ch = '0;
  logic [7:0]     c3_step = '0;
  logic           c3_ready;
  logic [2:0]     t3, l3;
  logic [1:0]     s3;

  nco_tick_scheduler #(.NCH(NCH), .W(W)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_step(cfg_step), .cfg_en(cfg_en),
    .tick(tick), .level(level), .slot(slot)
  );

  nco_tick_scheduler #(.NCH(3), .W(8)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
    .cfg_ch(c3_ch), .cfg_step(c3_step), .cfg_en(c3_en),
    .tick(t3), .level(l3), .slot(s3)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit go = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel phase as plain integers, one channel per clock.
  longint         m_phase [NCH];
  longint         m_step  [NCH];
  bit             m_en    [NCH];
  bit [NCH-1:0]   m_tick, m_level;
  int             m_slot;
  bit             m_pend;
  int             m_pch;
  longint         m_pstep;
  bit             m_pen;
  localparam longint MOD  = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);

  always @(posedge clk) begin : model
    int s;
    bit acc, app, bad;
    longint base, sum;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = 0; m_step[i] = 0; m_en[i] = 0;
      end
      m_tick = '0; m_level = '0; m_slot = 0; m_pend = 0;
    end else begin
      s   = m_slot;
      acc = cfg_valid && !m_pend;
      bad = m_pend && (m_pch >= NCH);
      app = m_pend && !bad && (m_pch == s);
      if (app) begin
        m_step[s] = m_pstep;
        m_en[s]   = m_pen;
      end
      m_tick = '0;
      if (m_en[s]) begin
        base = m_phase[s];
`ifdef NCO_PHASE_CLR_EN
        if (app) base = 0;
`endif
        sum        = base + m_step[s];
        m_tick[s]  = (sum >= MOD);
        m_phase[s] = sum % MOD;
        m_level[s] = (m_phase[s] >= HALF);
      end else if (app) begin
        m_phase[s] = 0;
        m_level[s] = 1'b0;
      end
      if (bad || app) m_pend = 0;
      if (acc) begin
        m_pend = 1; m_pch = int'(cfg_ch);
        m_pstep = longint'(cfg_step); m_pen = cfg_en;
      end
      m_slot = (s + 1) % NCH;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (go) begin
      chk("tick",  longint'(tick),  longint'(m_tick));
      chk("level", longint'(level), longint'(m_level));
      chk("slot",  longint'(slot),  longint'(m_slot));
      chk("ready", longint'(cfg_ready), longint'(!m_pend && !rst));
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    while (!cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, longint'(k < 20), 1);
  endtask

  task automatic send(input int ch, input logic [W-1:0] st, input logic en);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_step  = st;
    cfg_en    = en;
    wait_ready("send_timeout");
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_period(input int ch, input int exp_p, input string name);
    int last = -1;
    int seen = 0;
    for (int k = 0; k < 200 && seen < 4; k++) begin
      @(negedge clk);
      if (tick[ch]) begin
        if (last >= 0) chk(name, k - last, exp_p);
        last = k;
        seen++;
      end
    end
    chk({name, "_timeout"}, seen, 4);
  endtask

  task automatic count_bit(input int n, input int ch, output int cnt, input bit lvl);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += lvl ? int'(level[ch]) : int'(tick[ch]);
    end
  endtask

  initial begin : stim
    int cnt, other, k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b1;
    chk("rst_tick",  tick,  0);
    chk("rst_level", level, 0);
    chk("rst_slot",  slot,  0);
    chk("rst_ready", cfg_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1);

    c3_ch = 2'd0; c3_step = 8'h40; c3_en = 1'b1; c3_valid = 1'b1;
    @(negedge clk);
    c3_valid = 1'b0;
    cnt = 0;
    repeat (36) begin @(negedge clk); cnt += int'(t3[0]); end
    chk("d3_ch0_ticks", cnt, 3);
    c3_ch = 2'd3; c3_step = 8'h01; c3_en = 1'b1; c3_valid = 1'b1;
    @(negedge clk);
    c3_valid = 1'b0;
    chk("d3_bad_busy", c3_ready, 0);
    @(negedge clk);
    chk("d3_bad_clear", c3_ready, 1);
    cnt = 0; other = 0;
    repeat (36) begin
      @(negedge clk);
      cnt += int'(t3[0]);
      other += int'((t3[2:1] != 2'b00) || (l3[2:1] != 2'b00));
    end
    chk("d3_ch0_ticks_after", cnt, 3);
    chk("d3_others_quiet", other, 0);

    send(0, 32'h4000_0000, 1'b1);
    check_period(0, 16, "p0");
    count_bit(16, 0, cnt, 1'b1);
    chk("duty0", cnt, 8);

    send(1, 32'h8000_0000, 1'b1);
    check_period(1, 8, "p1");
    other = 0;
    repeat (64) begin
      @(negedge clk);
      other += int'(tick[0] && tick[1]);
    end
    chk("no_coincide", other, 0);
    check_period(0, 16, "p0b");

    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_step = 32'hFFFF_FFFF; cfg_en = 1'b1;
    wait_ready("b2b_first");
    @(negedge clk);
    chk("b2b_busy", cfg_ready, 0);
    cfg_ch = 2'd3; cfg_step = 32'h4000_0000; cfg_en = 1'b1;
    k = 0;
    while (!cfg_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_latency", longint'(k >= 1 && k <= 4), 1);
    @(negedge clk);
    cfg_valid = 1'b0;

    repeat (20) @(negedge clk);
    count_bit(16, 2, cnt, 1'b0);
    chk("ch2_ticking", cnt, 4);
    send(2, 32'hFFFF_FFFF, 1'b0);
    repeat (8) @(negedge clk);
    chk("ch2_level_off", level[2], 0);
    count_bit(40, 2, cnt, 1'b0);
    chk("ch2_no_ticks", cnt, 0);

    k = 0;
    while (level[3] && k < 40) begin @(negedge clk); k++; end
    while (!level[3] && k < 40) begin @(negedge clk); k++; end
    chk("lvl3_rise_timeout", longint'(k < 40), 1);
    send(3, 32'h1000_0000, 1'b1);
    repeat (4) @(negedge clk);
`ifdef NCO_PHASE_CLR_EN
    chk("retune_model", m_level[3], 0);
    chk("retune_level", level[3], 0);
`else
    chk("retune_model", m_level[3], 1);
    chk("retune_level", level[3], 1);
`endif

    k = 0;
    while (m_slot != 2 && k < 8) begin @(negedge clk); k++; end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_step = 32'h8000_0000; cfg_en = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", cfg_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_tick",  tick, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_slot",  slot, 0);
    other = 0;
    repeat (40) begin
      @(negedge clk);
      other += int'((tick != '0) || (level != '0));
    end
    chk("pend_discarded", other, 0);

    send(0, 32'h4000_0000, 1'b1);
    check_period(0, 16, "p0_final");

    go = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
